// File: rtl/project_param.sv
// Shared constants, state encoding and control-word layout for the PMSM drive
// supervisor.
package project_param;

  localparam int DATA_WIDTH = 16;

  localparam logic [7:0] BAND_BREAK_OPEN     = 8'h00;
  localparam logic [7:0] BAND_BREAK_CLOSE    = 8'h01;
  localparam logic [7:0] MOTOR_STOP_CMD      = 8'h00;
  localparam logic [7:0] MOTOR_START_CMD     = 8'h01;
  localparam logic [3:0] MOTOR_SPEED_MODE    = 4'h1;
  localparam logic [3:0] MOTOR_LOCATION_MODE = 4'h2;

  typedef enum logic [2:0] {
    ST_GATE_INIT,
    ST_CAN_INIT,
    ST_IDLE,
    ST_RUN,
    ST_FAULT
  } scu_state_e;

  // Every enable the supervisor drives, kept together so one register holds them.
  typedef struct packed {
    logic location_loop;
    logic location_detect;
    logic current_detect;
    logic current_loop;
    logic phase_forecast;
    logic speed_loop;
    logic gate_init;
    logic can_init;
    logic emergency_stop;
  } scu_ctrl_t;

  function automatic logic is_run_mode(input logic [3:0] mode);
    return (mode == MOTOR_SPEED_MODE) || (mode == MOTOR_LOCATION_MODE);
  endfunction

endpackage

// File: rtl/system_control_unit.sv
// Top-level PMSM drive supervisor: sequences gate-driver and CAN bring-up, then
// gates the control loops from CAN commands and latches faults into an e-stop.
module system_control_unit #(
  parameter int DATA_WIDTH = project_param::DATA_WIDTH
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  output logic                    location_loop_control_enable_out,
  output logic                    location_detection_enable_out,
  output logic                    current_enable_out,
  input  logic                    channela_detect_done_in,
  input  logic                    channelb_detect_done_in,
  input  logic                    channela_detect_err_in,
  input  logic                    channelb_detect_err_in,
  output logic [DATA_WIDTH-1:0]   current_detect_status_out,
  output logic                    current_loop_control_enable_out,
  output logic                    gate_driver_init_enable_out,
  input  logic                    gate_driver_init_done_in,
  input  logic                    gate_driver_error_in,
  output logic                    electrical_rotation_phase_forecast_enable_out,
  output logic                    can_init_enable_out,
  input  logic                    can_init_done_in,
  input  logic [DATA_WIDTH/2-1:0] band_breaks_mode_in,
  input  logic [DATA_WIDTH/2-1:0] pmsm_start_stop_mode_in,
  input  logic [DATA_WIDTH/4-1:0] pmsm_work_mode_in,
  output logic                    emergency_stop_out,
  output logic                    speed_control_enable_out,
  output logic                    system_initilization_done_out
);

  import project_param::*;

  scu_state_e             state_q, state_d;
  scu_ctrl_t              ctrl_q, ctrl_d;
  logic [DATA_WIDTH/4-1:0] mode_q, mode_d;
  logic [DATA_WIDTH-1:0]  status_q, status_d;
  logic                   init_done_q, init_done_d;

  logic [2:0] err_vec;
  logic       any_err;
  logic       start_req;
  logic       stop_req;
  logic       brake_closed;

  // Conversion-done strobes are part of the interface but carry no control meaning.
  logic unused_done;
  assign unused_done = channela_detect_done_in ^ channelb_detect_done_in;

  assign err_vec      = {gate_driver_error_in, channelb_detect_err_in, channela_detect_err_in};
  assign any_err      = |err_vec;
  assign start_req    = (pmsm_start_stop_mode_in == MOTOR_START_CMD);
  assign stop_req     = (pmsm_start_stop_mode_in == MOTOR_STOP_CMD);
  assign brake_closed = (band_breaks_mode_in == BAND_BREAK_CLOSE);

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    init_done_d = init_done_q;

    case (state_q)
      ST_GATE_INIT: if (gate_driver_init_done_in) state_d = ST_CAN_INIT;
      ST_CAN_INIT: begin
        if (can_init_done_in) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (any_err) begin
          state_d = ST_FAULT;
        end else if (start_req && brake_closed && is_run_mode(pmsm_work_mode_in)) begin
          state_d = ST_RUN;
          mode_d  = pmsm_work_mode_in;
        end
      end
      ST_RUN: begin
        if (any_err) begin
          state_d = ST_FAULT;
        end else if (stop_req || !brake_closed) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: if (stop_req) state_d = ST_IDLE;
      default:  state_d = ST_GATE_INIT;
    endcase
  end

  // Fault flags accumulate in every state and clear only on the way out of FAULT.
  always_comb begin
    if (state_q == ST_FAULT && state_d != ST_FAULT) begin
      status_d = '0;
    end else begin
      status_d = status_q | {{(DATA_WIDTH-3){1'b0}}, err_vec};
    end
  end

  // Outputs decode the next state so they register together with the transition.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      ST_GATE_INIT: ctrl_d.gate_init = 1'b1;
      ST_CAN_INIT:  ctrl_d.can_init  = 1'b1;
      ST_RUN: begin
        ctrl_d.current_detect = 1'b1;
        ctrl_d.current_loop   = 1'b1;
        ctrl_d.phase_forecast = 1'b1;
        ctrl_d.speed_loop     = 1'b1;
        if (mode_d == MOTOR_LOCATION_MODE) begin
          ctrl_d.location_loop   = 1'b1;
          ctrl_d.location_detect = 1'b1;
        end
      end
      ST_FAULT: ctrl_d.emergency_stop = 1'b1;
      default:  ctrl_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values; reset here is synchronous and active-high.
  always_ff @(posedge sys_clk) begin
    if (reset_n) begin
      state_q     <= ST_GATE_INIT;
      ctrl_q      <= '0;
      mode_q      <= '0;
      status_q    <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      mode_q      <= mode_d;
      status_q    <= status_d;
      init_done_q <= init_done_d;
    end
  end

  assign location_loop_control_enable_out              = ctrl_q.location_loop;
  assign location_detection_enable_out                 = ctrl_q.location_detect;
  assign current_enable_out                            = ctrl_q.current_detect;
  assign current_loop_control_enable_out               = ctrl_q.current_loop;
  assign electrical_rotation_phase_forecast_enable_out = ctrl_q.phase_forecast;
  assign speed_control_enable_out                      = ctrl_q.speed_loop;
  assign gate_driver_init_enable_out                   = ctrl_q.gate_init;
  assign can_init_enable_out                           = ctrl_q.can_init;
  assign emergency_stop_out                            = ctrl_q.emergency_stop;
  assign current_detect_status_out                     = status_q;
  assign system_initilization_done_out                 = init_done_q;

endmodule

// File: tb/tb_system_control_unit.sv
// Directed bench for system_control_unit: bring-up, loop gating, fault latching,
// recovery and mid-run reset.
module tb_system_control_unit;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        loc_loop, loc_det, cur_en, cur_loop, gate_en, phase_en, can_en;
  logic        estop, speed_en, init_done;
  logic [15:0] status;
  logic        cha_done, chb_done, cha_err, chb_err;
  logic        gate_done, gate_err, can_done;
  logic [7:0]  brake, start_stop;
  logic [3:0]  work_mode;

  int tests_run    = 0;
  int tests_failed = 0;

  // {loc_loop, loc_det, cur_en, cur_loop, phase, speed, gate, can, estop, init_done}
  localparam logic [9:0] E_RESET   = 10'b00_0000_0000;
  localparam logic [9:0] E_GATE    = 10'b00_0000_1000;
  localparam logic [9:0] E_CAN     = 10'b00_0000_0100;
  localparam logic [9:0] E_IDLE    = 10'b00_0000_0001;
  localparam logic [9:0] E_FAULT   = 10'b00_0000_0011;
  localparam logic [9:0] E_RUN_LOC = 10'b11_1111_0001;
  localparam logic [9:0] E_RUN_SPD = 10'b00_1111_0001;

  always #5 sys_clk = ~sys_clk;

  system_control_unit dut (
    .sys_clk                                       (sys_clk),
    .reset_n                                       (reset_n),
    .location_loop_control_enable_out              (loc_loop),
    .location_detection_enable_out                 (loc_det),
    .current_enable_out                            (cur_en),
    .channela_detect_done_in                       (cha_done),
    .channelb_detect_done_in                       (chb_done),
    .channela_detect_err_in                        (cha_err),
    .channelb_detect_err_in                        (chb_err),
    .current_detect_status_out                     (status),
    .current_loop_control_enable_out               (cur_loop),
    .gate_driver_init_enable_out                   (gate_en),
    .gate_driver_init_done_in                      (gate_done),
    .gate_driver_error_in                          (gate_err),
    .electrical_rotation_phase_forecast_enable_out (phase_en),
    .can_init_enable_out                           (can_en),
    .can_init_done_in                              (can_done),
    .band_breaks_mode_in                           (brake),
    .pmsm_start_stop_mode_in                       (start_stop),
    .pmsm_work_mode_in                             (work_mode),
    .emergency_stop_out                            (estop),
    .speed_control_enable_out                      (speed_en),
    .system_initilization_done_out                 (init_done)
  );

  function automatic logic [9:0] outs();
    return {loc_loop, loc_det, cur_en, cur_loop, phase_en, speed_en,
            gate_en, can_en, estop, init_done};
  endfunction

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (outs() !== E_RESET || status !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b/%h want %b/%h", outs(), status, E_RESET, 16'h0000);
    end
    reset_n = 1'b0;
    tick();
    tests_run++;
    if (outs() !== E_GATE) begin
      tests_failed++;
      $display("FAIL gate_init_entry: got %b want %b", outs(), E_GATE);
    end
  endtask

  task automatic test_init_sequence();
    logic held = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (outs() !== E_GATE) held = 1'b0;
    end
    tests_run++;
    if (held !== 1'b1) begin
      tests_failed++;
      $display("FAIL gate_enable_hold: got last %b want %b throughout", outs(), E_GATE);
    end
    gate_done = 1'b1;
    tick();
    tests_run++;
    if (outs() !== E_CAN) begin
      tests_failed++;
      $display("FAIL can_init_entry: got %b want %b", outs(), E_CAN);
    end
    can_done = 1'b1;
    tick();
    can_done = 1'b0;
    tests_run++;
    if (outs() !== E_IDLE || status !== 16'h0000) begin
      tests_failed++;
      $display("FAIL init_done: got %b/%h want %b/%h", outs(), status, E_IDLE, 16'h0000);
    end
  endtask

  task automatic test_idle_blocked();
    brake = 8'h00; work_mode = 4'h2; start_stop = 8'h01;
    tick();
    tests_run++;
    if (outs() !== E_IDLE) begin
      tests_failed++;
      $display("FAIL start_brake_open: got %b want %b", outs(), E_IDLE);
    end
    brake = 8'h01; work_mode = 4'h0;
    tick();
    tests_run++;
    if (outs() !== E_IDLE) begin
      tests_failed++;
      $display("FAIL start_bad_mode: got %b want %b", outs(), E_IDLE);
    end
  endtask

  task automatic test_run_location();
    work_mode = 4'h2;
    tick();
    tests_run++;
    if (outs() !== E_RUN_LOC) begin
      tests_failed++;
      $display("FAIL run_location: got %b want %b", outs(), E_RUN_LOC);
    end
    work_mode = 4'h1;
    tick();
    tests_run++;
    if (outs() !== E_RUN_LOC) begin
      tests_failed++;
      $display("FAIL run_mode_ignored: got %b want %b", outs(), E_RUN_LOC);
    end
  endtask

  task automatic test_fault_latch();
    cha_err = 1'b1;
    tick();
    cha_err = 1'b0;
    tests_run++;
    if (outs() !== E_FAULT || status !== 16'h0001) begin
      tests_failed++;
      $display("FAIL fault_cha: got %b/%h want %b/%h", outs(), status, E_FAULT, 16'h0001);
    end
    tick();
    tests_run++;
    if (outs() !== E_FAULT || status !== 16'h0001) begin
      tests_failed++;
      $display("FAIL fault_hold: got %b/%h want %b/%h", outs(), status, E_FAULT, 16'h0001);
    end
    chb_err = 1'b1;
    tick();
    chb_err = 1'b0;
    tests_run++;
    if (status !== 16'h0003) begin
      tests_failed++;
      $display("FAIL fault_chb: got %h want %h", status, 16'h0003);
    end
    gate_err = 1'b1;
    tick();
    gate_err = 1'b0;
    tests_run++;
    if (outs() !== E_FAULT || status !== 16'h0007) begin
      tests_failed++;
      $display("FAIL fault_gate: got %b/%h want %b/%h", outs(), status, E_FAULT, 16'h0007);
    end
  endtask

  task automatic test_recover_speed();
    start_stop = 8'h00;
    tick();
    tests_run++;
    if (outs() !== E_IDLE || status !== 16'h0000) begin
      tests_failed++;
      $display("FAIL fault_clear: got %b/%h want %b/%h", outs(), status, E_IDLE, 16'h0000);
    end
    work_mode = 4'h1; start_stop = 8'h01;
    tick();
    tests_run++;
    if (outs() !== E_RUN_SPD || status !== 16'h0000) begin
      tests_failed++;
      $display("FAIL run_speed: got %b/%h want %b/%h", outs(), status, E_RUN_SPD, 16'h0000);
    end
  endtask

  task automatic test_back_to_back();
    brake = 8'h00;
    tick();
    tests_run++;
    if (outs() !== E_IDLE) begin
      tests_failed++;
      $display("FAIL brake_release: got %b want %b", outs(), E_IDLE);
    end
    brake = 8'h01;
    tick();
    tests_run++;
    if (outs() !== E_RUN_SPD) begin
      tests_failed++;
      $display("FAIL brake_reclose: got %b want %b", outs(), E_RUN_SPD);
    end
    start_stop = 8'h00;
    tick();
    tests_run++;
    if (outs() !== E_IDLE) begin
      tests_failed++;
      $display("FAIL b2b_stop: got %b want %b", outs(), E_IDLE);
    end
    start_stop = 8'h01; work_mode = 4'h2;
    tick();
    tests_run++;
    if (outs() !== E_RUN_LOC) begin
      tests_failed++;
      $display("FAIL b2b_start_location: got %b want %b", outs(), E_RUN_LOC);
    end
  endtask

  task automatic test_reset_mid_run();
    gate_done = 1'b0;
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (outs() !== E_RESET || status !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midrun_reset: got %b/%h want %b/%h", outs(), status, E_RESET, 16'h0000);
    end
    reset_n = 1'b0;
    tick();
    tests_run++;
    if (outs() !== E_GATE) begin
      tests_failed++;
      $display("FAIL reinit_gate: got %b want %b", outs(), E_GATE);
    end
    gate_done = 1'b1;
    tick();
    chb_err = 1'b1;
    tick();
    chb_err = 1'b0;
    tests_run++;
    if (outs() !== E_CAN || status !== 16'h0002) begin
      tests_failed++;
      $display("FAIL init_error_latched: got %b/%h want %b/%h", outs(), status, E_CAN, 16'h0002);
    end
    can_done = 1'b1;
    tick();
    can_done = 1'b0;
    tests_run++;
    if (outs() !== E_RUN_RESTART_CHECK(outs())) begin
      tests_failed++;
      $display("FAIL reinit_done: got %b want %b", outs(), E_IDLE);
    end
  endtask

  // After re-init the command inputs still request location RUN, but the state
  // passes through IDLE first, so only IDLE is legal on this cycle.
  function automatic logic [9:0] E_RUN_RESTART_CHECK(input logic [9:0] unused_obs);
    return E_IDLE;
  endfunction

  initial begin
    reset_n    = 1'b1;
    cha_done   = 1'b0; chb_done = 1'b0;
    cha_err    = 1'b0; chb_err  = 1'b0;
    gate_done  = 1'b0; gate_err = 1'b0;
    can_done   = 1'b0;
    brake      = 8'h00;
    start_stop = 8'h00;
    work_mode  = 4'h0;

    test_reset();
    test_init_sequence();
    test_idle_blocked();
    test_run_location();
    test_fault_latch();
    test_recover_speed();
    test_back_to_back();
    test_reset_mid_run();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
